// File: rtl/ysyx_23060187_ifu_pkg.sv
// ysyx_23060187_ifu_pkg: shared state encoding and constants for the prefetching IFU
package ysyx_23060187_ifu_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} ifu_state_e;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_23060187_ifu_fifo.sv
// ysyx_23060187_ifu_fifo: synchronous FIFO with flush; head is masked to zero when empty
module ysyx_23060187_ifu_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          pop;
    assign pop     = pop_i && (cnt_q != '0);
    assign count_o = cnt_q;
    assign data_o  = (cnt_q == '0) ? '0 : mem_q[rd_q];
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/ysyx_23060187_ifu_pf.sv
// ysyx_23060187_ifu_pf: single-outstanding prefetching fetch unit with redirect flush and error halt
module ysyx_23060187_ifu_pf
    import ysyx_23060187_ifu_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               ILEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [XLEN-1:0]           req_addr_o,
    input  logic                      rsp_valid_i,
    output logic                      rsp_ready_o,
    input  logic [ILEN-1:0]           rsp_inst_i,
    input  logic                      rsp_err_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ILEN-1:0]           out_inst_o,
    output logic [XLEN-1:0]           out_pc_o,
    output logic                      out_err_o,
    input  logic                      redirect_valid_i,
    input  logic [XLEN-1:0]           redirect_pc_i,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = XLEN + ILEN + 1;
    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            push;
    logic [W-1:0]    head;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        case (state_q)
            IDLE: state_d = (count_o != CW'(DEPTH)) ? REQ : IDLE;
            REQ: if (req_ready_i) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + XLEN'(INST_BYTES);
                state_d  = WAIT;
            end
            WAIT: if (rsp_valid_i) begin
                push    = 1'b1;
                state_d = rsp_err_i ? HALT : IDLE;
            end
            DROP: state_d = rsp_valid_i ? IDLE : DROP;
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
        // redirect wins; an accepted-but-unanswered request must still be drained in DROP
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            push    = 1'b0;
            state_d = (state_q == WAIT || state_q == DROP) ? (rsp_valid_i ? IDLE : DROP) :
                      (state_q == REQ) ? (req_ready_i ? DROP : REQ) : IDLE;
        end
    end
    assign req_valid_o = (state_q == REQ);
    assign rsp_ready_o = (state_q == WAIT) || (state_q == DROP);
    assign req_addr_o  = pc_q;
    assign out_valid_o = (count_o != '0);
    assign {out_pc_o, out_inst_o, out_err_o} = head;
    ysyx_23060187_ifu_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .data_i  ({req_pc_q, rsp_inst_i, rsp_err_i}),
        .pop_i   (out_valid_o && out_ready_i),
        .data_o  (head),
        .count_o (count_o)
    );
endmodule

// File: tb/tb_ysyx_23060187_ifu_pf.sv
// tb_ysyx_23060187_ifu_pf: directed cycle-accurate bench for the prefetching IFU
module tb_ysyx_23060187_ifu_pf;
    logic        clk = 0, rst = 1;
    logic        req_valid_o, req_ready_i = 0;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i = 0, rsp_ready_o;
    logic [31:0] rsp_inst_i = 0;
    logic        rsp_err_i = 0;
    logic        out_valid_o, out_ready_i = 0;
    logic [31:0] out_inst_o, out_pc_o;
    logic        out_err_o;
    logic        redirect_valid_i = 0;
    logic [31:0] redirect_pc_i = 0;
    logic [2:0]  count_o;
    int checks = 0, errors = 0;

    ysyx_23060187_ifu_pf dut (
        .clk(clk), .rst(rst),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_inst_i(rsp_inst_i), .rsp_err_i(rsp_err_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_inst_o(out_inst_o),
        .out_pc_o(out_pc_o), .out_err_o(out_err_o),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (req_valid_o !== 1'b0 || rsp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_handshake got req_valid=%b rsp_ready=%b exp 0 0", req_valid_o, rsp_ready_o); end
        checks++; if (out_valid_o !== 1'b0 || out_err_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL reset_out got out_valid=%b out_err=%b count=%0d exp 0 0 0", out_valid_o, out_err_o, count_o); end
        checks++; if (req_addr_o !== 32'h8000_0000 || out_inst_o !== 32'h0 || out_pc_o !== 32'h0) begin errors++; $display("FAIL reset_data got addr=%h inst=%h pc=%h exp 80000000 0 0", req_addr_o, out_inst_o, out_pc_o); end
        rst = 0;
        checks++; if (req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_release_idle got req_valid=%b exp 0", req_valid_o); end
        tick();
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL first_req got v=%b addr=%h exp 1 80000000", req_valid_o, req_addr_o); end
    endtask

    task automatic test_stream();
        req_ready_i = 1; out_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a, ins;
            a = 32'h8000_0000 + 32'(i * 4);
            ins = 32'h0000_0013 + 32'(i * 256);
            checks++; if (req_valid_o !== 1'b1 || req_addr_o !== a) begin errors++; $display("FAIL stream_req%0d got v=%b addr=%h exp 1 %h", i, req_valid_o, req_addr_o, a); end
            tick();
            checks++; if (rsp_ready_o !== 1'b1 || req_valid_o !== 1'b0) begin errors++; $display("FAIL stream_wait%0d got rsp_ready=%b req_valid=%b exp 1 0", i, rsp_ready_o, req_valid_o); end
            rsp_valid_i = 1; rsp_inst_i = ins;
            tick();
            rsp_valid_i = 0;
            checks++; if (out_valid_o !== 1'b1 || out_pc_o !== a || out_inst_o !== ins || out_err_o !== 1'b0) begin errors++; $display("FAIL stream_out%0d got v=%b pc=%h inst=%h err=%b exp 1 %h %h 0", i, out_valid_o, out_pc_o, out_inst_o, out_err_o, a, ins); end
            tick();
        end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stream_drained got count=%0d exp 0", count_o); end
    endtask

    task automatic test_full();
        out_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rsp_valid_i = 1; rsp_inst_i = 32'(i);
            tick();
            rsp_valid_i = 0;
            checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL full_count%0d got %0d exp %0d", i, count_o, i + 1); end
            tick();
        end
        req_ready_i = 0;
        tick();
        checks++; if (req_valid_o !== 1'b0 || count_o !== 3'd4) begin errors++; $display("FAIL full_stall got req_valid=%b count=%0d exp 0 4", req_valid_o, count_o); end
        checks++; if (out_pc_o !== 32'h8000_000C || out_inst_o !== 32'h0) begin errors++; $display("FAIL full_head got pc=%h inst=%h exp 8000000c 0", out_pc_o, out_inst_o); end
        out_ready_i = 1;
        tick();
        out_ready_i = 0;
        checks++; if (req_valid_o !== 1'b0 || count_o !== 3'd3 || out_pc_o !== 32'h8000_0010) begin errors++; $display("FAIL full_pop got req_valid=%b count=%0d pc=%h exp 0 3 80000010", req_valid_o, count_o, out_pc_o); end
        tick();
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_001C) begin errors++; $display("FAIL full_resume got v=%b addr=%h exp 1 8000001c", req_valid_o, req_addr_o); end
    endtask

    task automatic test_redirect_wait();
        redirect_valid_i = 1; redirect_pc_i = 32'h8000_0100;
        tick();
        redirect_valid_i = 0;
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0100 || count_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL redir_req got v=%b addr=%h count=%0d ov=%b exp 1 80000100 0 0", req_valid_o, req_addr_o, count_o, out_valid_o); end
        req_ready_i = 1;
        tick();
        req_ready_i = 0;
        redirect_valid_i = 1; redirect_pc_i = 32'h8000_1000;
        tick();
        redirect_valid_i = 0;
        checks++; if (rsp_ready_o !== 1'b1 || req_valid_o !== 1'b0) begin errors++; $display("FAIL redir_drop got rsp_ready=%b req_valid=%b exp 1 0", rsp_ready_o, req_valid_o); end
        tick();
        rsp_valid_i = 1; rsp_inst_i = 32'h0000_0BAD;
        tick();
        rsp_valid_i = 0;
        checks++; if (out_valid_o !== 1'b0 || count_o !== 3'd0 || req_valid_o !== 1'b0) begin errors++; $display("FAIL redir_discard got ov=%b count=%0d req_valid=%b exp 0 0 0", out_valid_o, count_o, req_valid_o); end
        tick();
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_1000) begin errors++; $display("FAIL redir_next got v=%b addr=%h exp 1 80001000", req_valid_o, req_addr_o); end
    endtask

    task automatic test_redirect_pop();
        req_ready_i = 1;
        tick();
        req_ready_i = 0;
        rsp_valid_i = 1; rsp_inst_i = 32'h0000_1111;
        tick();
        rsp_valid_i = 0;
        checks++; if (count_o !== 3'd1 || out_pc_o !== 32'h8000_1000) begin errors++; $display("FAIL rpop_fill got count=%0d pc=%h exp 1 80001000", count_o, out_pc_o); end
        tick();
        req_ready_i = 1;
        tick();
        req_ready_i = 0;
        rsp_valid_i = 1; rsp_inst_i = 32'h0000_2222; out_ready_i = 1;
        redirect_valid_i = 1; redirect_pc_i = 32'h8000_2000;
        tick();
        rsp_valid_i = 0; out_ready_i = 0; redirect_valid_i = 0;
        checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || req_valid_o !== 1'b0) begin errors++; $display("FAIL rpop_flush got count=%0d ov=%b req_valid=%b exp 0 0 0", count_o, out_valid_o, req_valid_o); end
        tick();
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_2000 || count_o !== 3'd0) begin errors++; $display("FAIL rpop_next got v=%b addr=%h count=%0d exp 1 80002000 0", req_valid_o, req_addr_o, count_o); end
    endtask

    task automatic test_err();
        redirect_valid_i = 1; redirect_pc_i = 32'h8000_0008;
        tick();
        redirect_valid_i = 0;
        req_ready_i = 1;
        tick();
        req_ready_i = 0;
        rsp_valid_i = 1; rsp_err_i = 1; rsp_inst_i = 32'hDEAD_BEEF;
        tick();
        rsp_valid_i = 0; rsp_err_i = 0;
        checks++; if (out_valid_o !== 1'b1 || out_err_o !== 1'b1 || out_pc_o !== 32'h8000_0008 || out_inst_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_entry got v=%b err=%b pc=%h inst=%h exp 1 1 80000008 deadbeef", out_valid_o, out_err_o, out_pc_o, out_inst_o); end
        req_ready_i = 1;
        repeat (4) tick();
        checks++; if (req_valid_o !== 1'b0 || rsp_ready_o !== 1'b0 || count_o !== 3'd1) begin errors++; $display("FAIL err_halt got req_valid=%b rsp_ready=%b count=%0d exp 0 0 1", req_valid_o, rsp_ready_o, count_o); end
        req_ready_i = 0;
        redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 0;
        checks++; if (count_o !== 3'd0 || out_err_o !== 1'b0 || req_valid_o !== 1'b0) begin errors++; $display("FAIL err_flush got count=%0d err=%b req_valid=%b exp 0 0 0", count_o, out_err_o, req_valid_o); end
        tick();
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL err_resume got v=%b addr=%h exp 1 fffffffc", req_valid_o, req_addr_o); end
    endtask

    task automatic test_wrap();
        req_ready_i = 1;
        tick();
        req_ready_i = 0;
        rsp_valid_i = 1; rsp_inst_i = 32'h0000_3333;
        tick();
        rsp_valid_i = 0;
        checks++; if (out_pc_o !== 32'hFFFF_FFFC || out_inst_o !== 32'h0000_3333) begin errors++; $display("FAIL wrap_entry got pc=%h inst=%h exp fffffffc 00003333", out_pc_o, out_inst_o); end
        tick();
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got v=%b addr=%h exp 1 00000000", req_valid_o, req_addr_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_pop();
        test_err();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
